// File: rtl/alu_branch_idiv.sv
// Integer execution core: registered single-cycle ALU, registered branch/jump
// resolver and an iterative 32-bit radix-2 restoring divider with busy/done.
//
// Issue protocol: an operation is presented by holding valid_i high for one
// cycle with fu_code_i selecting the unit. ALU and BR issues are always taken.
// An IDIV issue is taken only when div_busy is low; otherwise it is dropped.
// There is no back-pressure signal. The caller must watch div_busy.
// Results: ALU/BR outputs are valid for exactly the cycle after issue and are
// zero otherwise. div_out is valid when div_done pulses and holds that value
// until a new result is loaded.
module alu_branch_idiv #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [1:0]      fu_code_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] in1_i,
   input  logic [XLEN-1:0] in2_i,
   output logic [XLEN-1:0] alu_out,
   output logic            br_taken,
   output logic [XLEN-1:0] br_target,
   output logic [XLEN-1:0] br_link,
   output logic [XLEN-1:0] div_out,
   output logic            div_busy,
   output logic            div_done,
   output logic            div_state_o
);

   localparam logic [1:0] FU_ALU  = 2'd1;
   localparam logic [1:0] FU_BR   = 2'd2;
   localparam logic [1:0] FU_IDIV = 2'd3;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_e;

   // ---------------- ALU ----------------
   logic [XLEN-1:0] alu_res;
   logic [4:0]      shamt;

   assign shamt = in2_i[4:0];

   // Combinational ALU function; unused op codes produce zero.
   always_comb begin
      alu_res = '0;
      case (op_i)
         4'd0:  alu_res = in1_i + in2_i;
         4'd1:  alu_res = in1_i - in2_i;
         4'd2:  alu_res = in1_i << shamt;
         4'd3:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in1_i) < $signed(in2_i))};
         4'd4:  alu_res = {{(XLEN-1){1'b0}}, (in1_i < in2_i)};
         4'd5:  alu_res = in1_i ^ in2_i;
         4'd6:  alu_res = in1_i >> shamt;
         4'd7:  alu_res = $signed(in1_i) >>> shamt;
         4'd8:  alu_res = in1_i | in2_i;
         4'd9:  alu_res = in1_i & in2_i;
         4'd10: alu_res = in2_i;
         default: alu_res = '0;
      endcase
   end

   // ---------------- Branch resolver ----------------
   logic            br_cond;
   logic [XLEN-1:0] br_tgt_c;
   logic [XLEN-1:0] br_lnk_c;
   logic [XLEN-1:0] jalr_sum;

   assign jalr_sum = in1_i + imm_i;

   // Branch condition, redirect target and link value.
   always_comb begin
      br_cond  = 1'b0;
      br_tgt_c = pc_i + imm_i;
      br_lnk_c = '0;
      case (op_i)
         4'd0: br_cond = (in1_i == in2_i);
         4'd1: br_cond = (in1_i != in2_i);
         4'd2: br_cond = ($signed(in1_i) < $signed(in2_i));
         4'd3: br_cond = ($signed(in1_i) >= $signed(in2_i));
         4'd4: br_cond = (in1_i < in2_i);
         4'd5: br_cond = (in1_i >= in2_i);
         4'd6: begin
            br_cond  = 1'b1;
            br_lnk_c = pc_i + 32'd4;
         end
         4'd7: begin
            br_cond  = 1'b1;
            br_tgt_c = {jalr_sum[XLEN-1:1], 1'b0};
            br_lnk_c = pc_i + 32'd4;
         end
         default: br_cond = 1'b0;
      endcase
   end

   // ALU and BR result registers; zero when not issued so results can be OR-muxed.
   always_ff @(posedge clock) begin
      if (reset) begin
         alu_out   <= '0;
         br_taken  <= 1'b0;
         br_target <= '0;
         br_link   <= '0;
      end else begin
         alu_out   <= (valid_i && fu_code_i == FU_ALU) ? alu_res : '0;
         br_taken  <= (valid_i && fu_code_i == FU_BR) ? br_cond : 1'b0;
         br_target <= (valid_i && fu_code_i == FU_BR) ? br_tgt_c : '0;
         br_link   <= (valid_i && fu_code_i == FU_BR) ? br_lnk_c : '0;
      end
   end

   // ---------------- Divider ----------------
   div_state_e      state_q, state_d;
   logic [4:0]      cnt_q;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            neg_quo_q, neg_rem_q, is_rem_q, dz_q;
   logic            accept;
   logic            last_iter;

   // Operand decode for a newly accepted divide.
   logic            signed_op, rem_op, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign accept    = valid_i && (fu_code_i == FU_IDIV) && (state_q == IDLE);
   assign last_iter = (state_q == BUSY) && (cnt_q == 5'd31);
   assign signed_op = (op_i == 4'd0) || (op_i == 4'd2);
   assign rem_op    = (op_i == 4'd2) || (op_i == 4'd3);
   assign a_neg     = signed_op && in1_i[XLEN-1];
   assign b_neg     = signed_op && in2_i[XLEN-1];
   assign a_mag     = a_neg ? (~in1_i + 32'd1) : in1_i;
   assign b_mag     = b_neg ? (~in2_i + 32'd1) : in2_i;

   // One restoring step: shift next dividend bit into the partial remainder.
   logic [XLEN:0]   shifted, diff;
   logic            ge;
   logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin, div_res;

   always_comb begin
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = ~diff[XLEN];
      rem_nx  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_nx  = {quo_q[XLEN-2:0], ge};
      quo_fin = dz_q ? '1 : (neg_quo_q ? (~quo_nx + 32'd1) : quo_nx);
      rem_fin = neg_rem_q ? (~rem_nx + 32'd1) : rem_nx;
      div_res = is_rem_q ? rem_fin : quo_fin;
   end

   // Divider state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Divider next state: one accept starts 32 busy cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = BUSY;
         BUSY:    if (last_iter) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign div_busy    = (state_q == BUSY);
   assign div_state_o = (state_q == BUSY);

   // Divider datapath: load magnitudes on accept, iterate while busy, publish on last step.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
         dz_q      <= 1'b0;
         div_out   <= '0;
         div_done  <= 1'b0;
      end else begin
         div_done <= 1'b0;
         if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            is_rem_q  <= rem_op;
            dz_q      <= (in2_i == '0);
         end else if (state_q == BUSY) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (last_iter) begin
               div_out  <= div_res;
               div_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_branch_idiv.sv
// Scoreboard bench for alu_branch_idiv: the driver pushes per-cycle expected
// outputs and expected divide results; the monitor pops and compares.
module tb_alu_branch_idiv;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid_i = 1'b0;
   logic [1:0]  fu_code_i = '0;
   logic [3:0]  op_i = '0;
   logic [31:0] pc_i = '0, imm_i = '0, in1_i = '0, in2_i = '0;
   logic [31:0] alu_out, br_target, br_link, div_out;
   logic        br_taken, div_busy, div_done, div_state_o;

   alu_branch_idiv dut (
      .clock(clock), .reset(reset), .valid_i(valid_i), .fu_code_i(fu_code_i),
      .op_i(op_i), .pc_i(pc_i), .imm_i(imm_i), .in1_i(in1_i), .in2_i(in2_i),
      .alu_out(alu_out), .br_taken(br_taken), .br_target(br_target),
      .br_link(br_link), .div_out(div_out), .div_busy(div_busy),
      .div_done(div_done), .div_state_o(div_state_o)
   );

   // Clock
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] alu;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] lnk;
      logic        busy;
      logic        done;
      logic        chk_div;
      logic [31:0] divv;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] div_exp_q[$];
   int          phase = 0;   // 0 idle, 1..32 busy sample index, 33 done sample
   int          checks = 0;
   int          failures = 0;

   // ---------------- Reference model ----------------
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      longint      sa, sb;
      sh = b[4:0];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:  return 32'(longint'(a) + longint'(b));
         4'd1:  return 32'(longint'(a) - longint'(b));
         4'd2:  return 32'(longint'(a) * (64'd1 << sh));
         4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a / (32'd1 << sh);
         4'd7:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic br_model(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic tk, output logic [31:0] tgt, output logic [31:0] lnk);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         4'd0: tk = (a == b);
         4'd1: tk = (a != b);
         4'd2: tk = (sa < sb);
         4'd3: tk = (sa >= sb);
         4'd4: tk = (a < b);
         4'd5: tk = (a >= b);
         4'd6, 4'd7: tk = 1'b1;
         default: tk = 1'b0;
      endcase
      tgt = (op == 4'd7) ? ((a + imm) & ~32'h1) : (pc + imm);
      lnk = (op == 4'd6 || op == 4'd7) ? pc + 32'd4 : 32'd0;
   endtask

   function automatic logic [31:0] div_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic is_s, is_r;
      int   sa, sb;
      is_s = (op == 4'd0) || (op == 4'd2);
      is_r = (op == 4'd2) || (op == 4'd3);
      if (b == 32'd0) return is_r ? a : 32'hFFFF_FFFF;
      if (is_s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_r ? 32'd0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return is_r ? 32'(sa % sb) : 32'(sa / sb);
      end
      return is_r ? (a % b) : (a / b);
   endfunction

   // ---------------- Driver ----------------
   task automatic drive_cycle(input logic rst, input logic v, input logic [1:0] fu, input logic [3:0] op,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(posedge clock);
      #2;
      reset = rst; valid_i = v; fu_code_i = fu; op_i = op;
      pc_i = pc; imm_i = imm; in1_i = a; in2_i = b;
      e = '0;
      if (rst) begin
         phase = 0;
         div_exp_q.delete();
         e.chk_div = 1'b1;
         e.divv    = 32'd0;
      end else begin
         if (v && fu == 2'd1) e.alu = alu_model(op, a, b);
         if (v && fu == 2'd2) br_model(op, pc, imm, a, b, e.tk, e.tgt, e.lnk);
         if (phase == 0 || phase == 33) begin
            if (v && fu == 2'd3) begin
               phase = 1;
               div_exp_q.push_back(div_model(op, a, b));
            end else begin
               phase = 0;
            end
         end else begin
            phase = phase + 1;
         end
         e.busy = (phase >= 1 && phase <= 32);
         e.done = (phase == 33);
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      drive_cycle(1'b0, 1'b1, 2'd1, op, 32'd0, 32'd0, a, b);
   endtask

   task automatic br(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [31:0] a, input logic [31:0] b);
      drive_cycle(1'b0, 1'b1, 2'd2, op, pc, imm, a, b);
   endtask

   task automatic div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      drive_cycle(1'b0, 1'b1, 2'd3, op, 32'd0, 32'd0, a, b);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- Scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alu_out", alu_out, e.alu);
            check("br_taken", 32'(br_taken), 32'(e.tk));
            check("br_target", br_target, e.tgt);
            check("br_link", br_link, e.lnk);
            check("div_busy", 32'(div_busy), 32'(e.busy));
            check("div_done", 32'(div_done), 32'(e.done));
            if (e.chk_div) check("div_out_reset", div_out, e.divv);
            if (div_done === 1'b1 && div_exp_q.size() > 0)
               check("div_out", div_out, div_exp_q.pop_front());
         end
      end
   end

   // ---------------- Stimulus ----------------
   initial begin
      drive_cycle(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      drive_cycle(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

      // ALU corner cases, then a non-issue cycle returns outputs to zero
      alu(4'd0, 32'h7FFF_FFFF, 32'd1);
      alu(4'd7, 32'h8000_0000, 32'd4);
      alu(4'd4, 32'd1, 32'hFFFF_FFFF);
      alu(4'd3, 32'hFFFF_FFFF, 32'd0);
      alu(4'd12, 32'd5, 32'd6);
      idle(1);

      // Branch corner cases
      br(4'd2, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd0);
      br(4'd7, 32'h40, 32'd0, 32'h203, 32'd0);
      br(4'd6, 32'h80, 32'hFFFF_FFF0, 32'd0, 32'd0);
      br(4'd5, 32'h10, 32'h8, 32'd1, 32'hFFFF_FFFF);
      idle(1);

      // Divides issued back-to-back in each done cycle; one drop while busy
      div(4'd0, 32'hFFFF_FFF9, 32'd2);
      div(4'd3, 32'd9, 32'd4);
      idle(31);
      div(4'd2, 32'hFFFF_FFF9, 32'd2);  idle(32);
      div(4'd1, 32'd100, 32'd7);        idle(32);
      div(4'd3, 32'd100, 32'd7);        idle(32);
      div(4'd0, 32'd5, 32'd0);          idle(32);
      div(4'd2, 32'd5, 32'd0);          idle(32);
      div(4'd0, 32'h8000_0000, 32'hFFFF_FFFF); idle(32);
      div(4'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(33);

      // Reset mid-division, then confirm no stale done appears
      div(4'd1, 32'd1000, 32'd3);
      idle(10);
      drive_cycle(1'b1, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      idle(40);

      // Randomized mixed traffic
      for (int i = 0; i < 1500; i++) begin
         logic       v, r;
         logic [1:0] fu;
         logic [3:0] op;
         v  = ($urandom_range(0, 4) != 0);
         fu = 2'($urandom_range(0, 3));
         op = (fu == 2'd3) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
         r  = ($urandom_range(0, 299) == 0);
         drive_cycle(r, v, fu, op, $urandom, rnd_val(), rnd_val(), rnd_val());
      end
      idle(40);

      @(posedge clock);
      @(posedge clock);
      #3;
      check("div_results_pending", 32'(div_exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
